// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
package restoring_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_divider_div_step.sv
// One combinational restoring-division iteration: shift, trial subtract, restore, quotient bit.
module div_step
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_dvd
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_qbit;
    logic             w_unused;

    assign w_shift = {i_rem, i_dvd[WIDTH-1]};
    // Extra top bit acts as the borrow: set means the trial subtraction went negative.
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_dvs};
    assign w_qbit  = ~w_diff[WIDTH+1];

    // A kept difference is always below the divisor, so its bit WIDTH is zero.
    assign w_unused = w_diff[WIDTH];

    assign o_rem = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_dvd = {i_dvd[WIDTH-2:0], w_qbit};

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per RUN cycle, results held between DONEs.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       r_state, w_state_next;
    logic [WIDTH-1:0] r_rem, w_rem_next;
    logic [WIDTH-1:0] r_dvd, w_dvd_next;
    logic [WIDTH-1:0] r_dvs, w_dvs_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [WIDTH-1:0] r_quot, w_quot_next;
    logic [WIDTH-1:0] r_remo, w_remo_next;
    logic             r_dbz, w_dbz_next;

    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_dvd;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_dvd (w_step_dvd)
    );

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_dvd   <= w_dvd_next;
            r_dvs   <= w_dvs_next;
            r_cnt   <= w_cnt_next;
            r_quot  <= w_quot_next;
            r_remo  <= w_remo_next;
            r_dbz   <= w_dbz_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_dvd_next   = r_dvd;
        w_dvs_next   = r_dvs;
        w_cnt_next   = r_cnt;
        w_quot_next  = r_quot;
        w_remo_next  = r_remo;
        w_dbz_next   = r_dbz;
        case (r_state)
            ST_RUN: begin
                w_rem_next = w_step_rem;
                w_dvd_next = w_step_dvd;
                w_cnt_next = r_cnt - CW'(1);
                // Visible results only change on the final iteration edge.
                if (r_cnt == CW'(1)) begin
                    w_quot_next  = w_step_dvd;
                    w_remo_next  = w_step_rem;
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
                if (i_start) begin
                    if (i_divisor == '0) begin
                        w_quot_next  = '1;
                        w_remo_next  = i_dividend;
                        w_dbz_next   = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_rem_next   = '0;
                        w_dvd_next   = i_dividend;
                        w_dvs_next   = i_divisor;
                        w_cnt_next   = CW'(WIDTH);
                        w_dbz_next   = 1'b0;
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    assign o_busy        = (r_state == ST_RUN);
    assign o_done        = (r_state == ST_DONE);
    assign o_quotient    = r_quot;
    assign o_remainder   = r_remo;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive checks of the 4-bit restoring divider.
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    int n_pass  = 0;
    int n_total = 0;

    restoring_divider #(.WIDTH(4)) dut (
        .i_clock       (clk),
        .i_resetn      (rst_n),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    // Issues one request and waits (bounded) for Done; reports whether results stayed at pq/pr during RUN.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] pq, input logic [3:0] pr,
                           output logic [3:0] q, output logic [3:0] r, output logic dz,
                           output int busy_n, output bit got_done, output bit held, output bit pulse1);
        busy_n = 0; got_done = 0; held = 1; pulse1 = 0;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            if (quotient !== pq || remainder !== pr) held = 0;
            @(negedge clk);
        end
        q = quotient; r = remainder; dz = dbz;
        @(negedge clk);
        pulse1 = (done === 1'b0);
    endtask

    task automatic test_reset();
        #3;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags busy/done=%b required 00", {busy, done}); else n_pass++;
        n_total++; if (quotient !== 4'd0) $display("FAIL reset_quot got %0d required 0", quotient); else n_pass++;
        n_total++; if (remainder !== 4'd0) $display("FAIL reset_rem got %0d required 0", remainder); else n_pass++;
        n_total++; if (dbz !== 1'b0) $display("FAIL reset_dbz got %b required 0", dbz); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: busy=%b done=%b q=%0d r=%0d dbz=%b", busy, done, quotient, remainder, dbz);
    endtask

    task automatic test_basic();
        logic [3:0] q, r; logic dz; int bn; bit gd, hd, p1;
        run_div(4'd13, 4'd3, 4'd0, 4'd0, q, r, dz, bn, gd, hd, p1);
        $display("13/3: q=%0d r=%0d dbz=%b busy_cycles=%0d", q, r, dz, bn);
        n_total++; if (!gd) $display("FAIL basic_done no Done within bound"); else n_pass++;
        n_total++; if ({q, r} !== {4'd4, 4'd1}) $display("FAIL basic_result got %0d/%0d required 4/1", q, r); else n_pass++;
        n_total++; if (dz !== 1'b0) $display("FAIL basic_dbz got %b required 0", dz); else n_pass++;
        n_total++; if (bn !== 4) $display("FAIL basic_latency busy cycles %0d required 4", bn); else n_pass++;
        n_total++; if (!hd) $display("FAIL basic_hold results changed during RUN, required 0/0"); else n_pass++;
        n_total++; if (!p1) $display("FAIL basic_pulse Done still high after 1 cycle, required low"); else n_pass++;
    endtask

    task automatic test_corners();
        logic [3:0] q, r; logic dz; int bn; bit gd, hd, p1;
        run_div(4'd15, 4'd1, 4'd4, 4'd1, q, r, dz, bn, gd, hd, p1);
        $display("15/1: q=%0d r=%0d dbz=%b", q, r, dz);
        n_total++; if (!gd || {q, r} !== {4'd15, 4'd0}) $display("FAIL div_by_one got %0d/%0d done=%b required 15/0", q, r, gd); else n_pass++;
        n_total++; if (!hd) $display("FAIL div_by_one_hold results changed during RUN, required 4/1"); else n_pass++;
        run_div(4'd3, 4'd9, 4'd15, 4'd0, q, r, dz, bn, gd, hd, p1);
        $display("3/9: q=%0d r=%0d dbz=%b", q, r, dz);
        n_total++; if (!gd || {q, r} !== {4'd0, 4'd3}) $display("FAIL small_dividend got %0d/%0d done=%b required 0/3", q, r, gd); else n_pass++;
    endtask

    task automatic test_start_in_run();
        int bn; bit gd;
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        dividend = 4'd6; divisor = 4'd2;
        bn = 0; gd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin gd = 1; break; end
            if (busy === 1'b1) bn++;
            @(negedge clk);
        end
        $display("13/3 with start held: q=%0d r=%0d busy_cycles=%0d", quotient, remainder, bn);
        n_total++; if (!gd || {quotient, remainder} !== {4'd4, 4'd1}) $display("FAIL ignore_start got %0d/%0d done=%b required 4/1", quotient, remainder, gd); else n_pass++;
        n_total++; if (bn !== 4) $display("FAIL ignore_start_latency busy cycles %0d required 4", bn); else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_total++; if ({busy, done} !== 2'b10) $display("FAIL back_to_back busy/done=%b required 10", {busy, done}); else n_pass++;
        bn = 0; gd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin gd = 1; break; end
            if (busy === 1'b1) bn++;
            @(negedge clk);
        end
        $display("6/2 back-to-back: q=%0d r=%0d busy_cycles=%0d", quotient, remainder, bn);
        n_total++; if (!gd || {quotient, remainder} !== {4'd3, 4'd0}) $display("FAIL back_to_back_result got %0d/%0d done=%b required 3/0", quotient, remainder, gd); else n_pass++;
        n_total++; if (bn !== 4) $display("FAIL back_to_back_latency busy cycles %0d required 4", bn); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        logic [3:0] q, r; logic dz; int bn; bit gd, hd, p1;
        run_div(4'd7, 4'd0, 4'd3, 4'd0, q, r, dz, bn, gd, hd, p1);
        $display("7/0: q=%0d r=%0d dbz=%b busy_cycles=%0d", q, r, dz, bn);
        n_total++; if (!gd || {q, r} !== {4'd15, 4'd7}) $display("FAIL div_zero_result got %0d/%0d done=%b required 15/7", q, r, gd); else n_pass++;
        n_total++; if (dz !== 1'b1) $display("FAIL div_zero_flag got %b required 1", dz); else n_pass++;
        n_total++; if (bn !== 0) $display("FAIL div_zero_busy busy cycles %0d required 0", bn); else n_pass++;
        n_total++; if (!p1) $display("FAIL div_zero_pulse Done still high after 1 cycle, required low"); else n_pass++;
    endtask

    task automatic test_reset_in_run();
        logic [3:0] q, r; logic dz; int bn, dn; bit gd, hd, p1;
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset in RUN: busy=%b done=%b q=%0d r=%0d dbz=%b", busy, done, quotient, remainder, dbz);
        n_total++; if ({busy, done, dbz} !== 3'b000) $display("FAIL abort_flags busy/done/dbz=%b required 000", {busy, done, dbz}); else n_pass++;
        n_total++; if ({quotient, remainder} !== 8'd0) $display("FAIL abort_results got %0d/%0d required 0/0", quotient, remainder); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        n_total++; if (dn !== 0) $display("FAIL abort_no_done saw %0d Done cycles required 0", dn); else n_pass++;
        run_div(4'd9, 4'd2, 4'd0, 4'd0, q, r, dz, bn, gd, hd, p1);
        $display("9/2 after reset: q=%0d r=%0d dbz=%b busy_cycles=%0d", q, r, dz, bn);
        n_total++; if (!gd || {q, r, dz} !== {4'd4, 4'd1, 1'b0}) $display("FAIL post_reset got %0d/%0d dbz=%b done=%b required 4/1/0", q, r, dz, gd); else n_pass++;
        n_total++; if (bn !== 4) $display("FAIL post_reset_latency busy cycles %0d required 4", bn); else n_pass++;
    endtask

    task automatic test_sweep();
        int order[256];
        int tmp, j, bn, errs;
        logic [3:0] a, b, q, r, eq, er, pq, pr;
        logic dz, edz;
        bit gd, hd, p1;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        pq = 4'd4; pr = 4'd1; errs = 0;
        for (int i = 0; i < 256; i++) begin
            a = 4'(order[i] / 16);
            b = 4'(order[i] % 16);
            if (b == 4'd0) begin
                eq = 4'd15; er = a; edz = 1'b1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0;
            end
            run_div(a, b, pq, pr, q, r, dz, bn, gd, hd, p1);
            $display("sweep %0d/%0d: q=%0d r=%0d dbz=%b", a, b, q, r, dz);
            n_total++;
            if (!gd || {q, r, dz} !== {eq, er, edz} || bn !== ((b == 4'd0) ? 0 : 4) || !hd || !p1) begin
                $display("FAIL sweep_%0d_%0d got %0d/%0d dbz=%b busy=%0d done=%b hold=%b pulse=%b required %0d/%0d dbz=%b",
                         a, b, q, r, dz, bn, gd, hd, p1, eq, er, edz);
                errs++;
            end else begin
                n_pass++;
            end
            pq = eq; pr = er;
        end
        $display("sweep: %0d pairs differed", errs);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        test_reset();
        test_basic();
        test_corners();
        test_start_in_run();
        test_div_zero();
        test_reset_in_run();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand and result bit width; legal range 2..16.
REQ-002 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Start  input  1  SHALL be the request to begin a division, sampled on the rising edge of Clock.
REQ-005 Dividend  input  WIDTH  SHALL be the unsigned dividend, captured when Start is accepted.
REQ-006 Divisor  input  WIDTH  SHALL be the unsigned divisor, captured when Start is accepted.
REQ-007 Busy  output  1  SHALL be high while a division is in progress (state RUN).
REQ-008 Done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-009 Quotient  output  WIDTH  SHALL be the registered quotient.
REQ-010 Remainder  output  WIDTH  SHALL be the registered remainder.
REQ-011 DivByZero  output  1  SHALL flag that the last accepted Divisor was zero.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 Start SHALL be accepted only in IDLE or DONE; in RUN it SHALL be ignored with no effect.
REQ-014 On acceptance with Divisor != 0, the block SHALL latch the operands, clear the partial remainder, load iteration counter = WIDTH, clear DivByZero and enter RUN.
REQ-015 Each RUN cycle SHALL perform one restoring step: shift {remainder, dividend} left 1, trial-subtract Divisor from the WIDTH+1-bit remainder, keep the result and set the quotient LSB = 1 if the result is non-negative, otherwise restore and set the LSB = 0, then decrement the counter.
REQ-016 After exactly WIDTH RUN cycles, the block SHALL update Quotient/Remainder and enter DONE, so that Done is high in the cycle following the WIDTH-th iteration edge (latency WIDTH+1 edges from the Start-sampling edge).
REQ-017 On acceptance with Divisor == 0, the block SHALL skip RUN and enter DONE on the next edge with Quotient = all ones, Remainder = Dividend and DivByZero = 1.
REQ-018 DONE SHALL last exactly one cycle; the next state SHALL be RUN or DONE if Start is accepted (back-to-back), otherwise IDLE.
REQ-019 Quotient, Remainder and DivByZero SHALL hold their values from DONE until the next DONE; they SHALL NOT show intermediate RUN values.
REQ-020 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder with Remainder < Divisor for every nonzero Divisor, including Dividend < Divisor (Quotient = 0, Remainder = Dividend).
REQ-021 Operand inputs SHALL be don't-care outside the Start-acceptance edge.

Reset
REQ-022 Resetn low SHALL immediately force state IDLE, Busy = 0, Done = 0, Quotient = 0, Remainder = 0, DivByZero = 0, counter = 0 and the internal shift registers = 0, irrespective of Clock.
REQ-023 A reset during RUN SHALL abort the division with no Done pulse; the first Start after Resetn rises SHALL behave as from power-up.

Structure
REQ-024 The state encoding (IDLE/RUN/DONE) and the WIDTH default SHALL reside in the shared divider package.
REQ-025 One combinational sub-module, div_step (shift, trial subtract, restore, quotient bit), SHALL implement REQ-015; the FSM, counter and registers SHALL stay in restoring_divider.

Verification (WIDTH = 4)
REQ-026 Dividend = 13, Divisor = 3, Start pulse -> Busy for 4 cycles, then Done for 1 cycle with Quotient = 4, Remainder = 1, DivByZero = 0.
REQ-027 Dividend = 15, Divisor = 1 -> Quotient = 15, Remainder = 0; Dividend = 3, Divisor = 9 -> Quotient = 0, Remainder = 3.
REQ-028 Dividend = 7, Divisor = 0 -> Done on the first edge after the Start edge with Quotient = 15, Remainder = 7, DivByZero = 1, and Busy never high.
REQ-029 Start for 13/3, then Start for 6/2 held high during RUN -> the second request is ignored and the results are 4/1; Start asserted in DONE with 6/2 -> a second Done follows with Quotient = 3, Remainder = 0.
REQ-030 Resetn low in the 2nd RUN cycle of 13/3 -> all outputs 0 immediately and no Done; the next 9/2 request -> Quotient = 4, Remainder = 1.
REQ-031 Exhaustive 256-pair random-order sweep -> every result matches REQ-020 or REQ-017.
